leaf_stream_bridge: RTL and testbench
=====================================

# leaf_stream_bridge

Parametrised leaf-side bridge between one BFT packet port and N user AXI-Stream-style operator ports. It replaces the fixed single-port leaf glue. Ingress packets are steered by destination-port field into per-port FIFOs feeding operator inputs. Egress operator outputs are round-robin arbitrated into packets, each stamped with a per-port destination.

## Interface
- PAYLOAD_BITS, 32, user data width
- NUM_LEAF_BITS, 3, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- PACKET_BITS, 1+NUM_LEAF_BITS+NUM_PORT_BITS+PAYLOAD_BITS (40), derived packet width, not overridable
- NUM_IN_PORTS, 2, user input streams (BFT→user), 1..2^NUM_PORT_BITS
- NUM_OUT_PORTS, 2, user output streams (user→BFT), 1..16
- FIFO_DEPTH, 16, per-ingress-port FIFO entries, power of two, ≥2
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- din_leaf_bft2interface  in  PACKET_BITS  {valid, leaf, port, payload}, MSB first
- dout_leaf_interface2bft  out  PACKET_BITS  registered egress packet, same format
- dout_leaf_interface2user  out  NUM_IN_PORTS*PAYLOAD_BITS  ingress data, port i at slice i
- vld_interface2user  out  NUM_IN_PORTS  ingress valid
- ack_user2interface  in  NUM_IN_PORTS  ingress ready from operator
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  egress data
- vld_user2interface  in  NUM_OUT_PORTS  egress valid
- ack_interface2user  out  NUM_OUT_PORTS  egress ready (one-hot or zero)
- dest_cfg  in  NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)  {leaf,port} per egress port, quasi-static
- drop_cnt  out  16  ingress FIFO-full drops, saturating
- bad_port_cnt  out  16  ingress packets with port ≥ NUM_IN_PORTS, saturating
- tx_cnt  out  NUM_OUT_PORTS*32  packets sent per egress port, wrapping

## Operation
- Ingress: din sampled into input register every edge. Registered packet with valid=1 and port p < NUM_IN_PORTS is written into FIFO p on the next edge. Leaf field is ignored.
- FIFO p full: packet dropped, drop_cnt++. Exception: a pop occurring on the same edge accepts the write.
- port ≥ NUM_IN_PORTS: dropped, bad_port_cnt++.
- vld_interface2user[p] = FIFO p non-empty. Head data is presented on its slice. Pop on vld&ack.
- Egress: round-robin pointer rr (reset 0). ack_interface2user is one-hot for the first index ≥rr (wrapping) with vld=1. It is combinational from vld and rr.
- On transfer at index g: dout ← {1, dest_cfg[g], payload[g]} and rr ← g+1 mod NUM_OUT_PORTS.
- No transfer: dout valid bit ← 0. Other bits hold their last value.
- No BFT backpressure; at most one egress packet per cycle.
- Counters saturate at 0xFFFF (drop/bad) or wrap at 2^32 (tx).

## Timing
- Reset: all outputs 0, FIFOs empty, rr=0, counters 0, input register cleared.
- Reset mid-operation clears everything; in-flight packets are lost.
- Ingress latency: packet on din at edge N → vld_interface2user high after edge N+1. Full FIFO throughput is 1 packet/cycle/aggregate.
- Egress latency: vld&ack at edge M → dout valid after edge M. Back-to-back transfers every cycle are allowed.
- Simultaneous ingress write and user pop on the same FIFO is legal at any occupancy.
- dest_cfg is sampled on the transfer edge only.

## Configuration
- LEAF_BRIDGE_STATS_EN defined: drop_cnt, bad_port_cnt and tx_cnt are implemented as specified.
- Undefined: the counter registers are not built and the three outputs are tied to 0. Drop behaviour is unchanged.
- The port list is identical in both builds.

## Structure
- Package leaf_bridge_pkg: field offsets (VALID_BIT, LEAF_LSB, PORT_LSB), the PACKET_BITS derivation function, and the counter width constants.
- Sub-module leaf_port_fifo: synchronous FIFO, FIFO_DEPTH×PAYLOAD_BITS, with full/empty, simultaneous read/write, and async active-low reset. It is instantiated NUM_IN_PORTS times.
- Arbiter and packet formatter are kept inline.

## Test plan
- Reset, then a packet with port=1 and payload 0xDEADBEEF: vld_interface2user[1] rises 2 edges later with data 0xDEADBEEF. Port 0 stays idle.
- Ack held 0 while 17 packets are sent to port 0 (depth 16): 16 are stored, drop_cnt=1. Then drain with ack=1: 16 words come out in order.
- Packet with port=5 (NUM_IN_PORTS=2): nothing is stored, bad_port_cnt=1.
- Both egress vld held high, dest_cfg = {3,2} and {6,1}: dout alternates between port 0 and port 1 every cycle with matching leaf/port fields, and tx_cnt advances by 1 each.
- FIFO full while a pop and a push occur on the same edge: push accepted, occupancy stays 16, drop_cnt unchanged.
- reset_n asserted mid-stream: all outputs are 0 immediately. After release, the first egress grant goes to port 0.

Source files
------------

// File: rtl/leaf_stream_bridge_pkg.sv
// leaf_bridge_pkg: BFT packet field layout and counter widths
// shared by the leaf stream bridge and its interface.
package leaf_bridge_pkg;

  localparam int CNT_BITS    = 16;
  localparam int TX_CNT_BITS = 32;

  function automatic int packet_bits(int pl, int lf, int pt);
    return 1 + lf + pt + pl;
  endfunction

  function automatic int valid_bit(int pl, int lf, int pt);
    return lf + pt + pl;
  endfunction

  function automatic int leaf_lsb(int pl, int pt);
    return pt + pl;
  endfunction

  function automatic int port_lsb(int pl);
    return pl;
  endfunction

  // layout of the default 40-bit packet {valid, leaf, port, payload}
  localparam int VALID_BIT = valid_bit(32, 3, 4);
  localparam int LEAF_LSB  = leaf_lsb(32, 4);
  localparam int PORT_LSB  = port_lsb(32);

endpackage

// File: rtl/leaf_stream_bridge_if.sv
// leaf_stream_bridge_if: BFT packet port, user ingress/egress streams
// and statistics of the leaf bridge, with bridge/environment modports.
interface leaf_stream_bridge_if
  import leaf_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 3,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_IN_PORTS  = 2,
  parameter int NUM_OUT_PORTS = 2
);

  localparam int PKT_W  = packet_bits(PAYLOAD_BITS, NUM_LEAF_BITS,
                                      NUM_PORT_BITS);
  localparam int DEST_W = NUM_LEAF_BITS + NUM_PORT_BITS;

  logic [PKT_W-1:0]                      din_leaf_bft2interface;
  logic [PKT_W-1:0]                      dout_leaf_interface2bft;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user;
  logic [NUM_IN_PORTS-1:0]               vld_interface2user;
  logic [NUM_IN_PORTS-1:0]               ack_user2interface;
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
  logic [NUM_OUT_PORTS*DEST_W-1:0]       dest_cfg;
  logic [CNT_BITS-1:0]                   drop_cnt;
  logic [CNT_BITS-1:0]                   bad_port_cnt;
  logic [NUM_OUT_PORTS*TX_CNT_BITS-1:0]  tx_cnt;

  modport slave (
    input  din_leaf_bft2interface,
    input  ack_user2interface,
    input  din_leaf_user2interface,
    input  vld_user2interface,
    input  dest_cfg,
    output dout_leaf_interface2bft,
    output dout_leaf_interface2user,
    output vld_interface2user,
    output ack_interface2user,
    output drop_cnt,
    output bad_port_cnt,
    output tx_cnt
  );

  modport master (
    output din_leaf_bft2interface,
    output ack_user2interface,
    output din_leaf_user2interface,
    output vld_user2interface,
    output dest_cfg,
    input  dout_leaf_interface2bft,
    input  dout_leaf_interface2user,
    input  vld_interface2user,
    input  ack_interface2user,
    input  drop_cnt,
    input  bad_port_cnt,
    input  tx_cnt
  );

endinterface

// File: rtl/leaf_stream_bridge_fifo.sv
// leaf_port_fifo: synchronous FIFO with full/empty flags; a pop on the
// same edge frees the slot so a push into a full FIFO is accepted.
module leaf_port_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_rd;
  logic             w_wr;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_data  = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/leaf_stream_bridge.sv
// leaf_stream_bridge: BFT packet port <-> N user streams, ingress FIFOs
// and round-robin egress; LEAF_BRIDGE_STATS_EN builds the counters.
module leaf_stream_bridge
  import leaf_bridge_pkg::*;
#(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 3,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_IN_PORTS  = 2,
  parameter int NUM_OUT_PORTS = 2,
  parameter int FIFO_DEPTH    = 16
) (
  input logic                clk,
  input logic                reset_n,
  leaf_stream_bridge_if.slave bus
);

  localparam int PKT_W  = packet_bits(PAYLOAD_BITS, NUM_LEAF_BITS,
                                      NUM_PORT_BITS);
  localparam int VB     = valid_bit(PAYLOAD_BITS, NUM_LEAF_BITS,
                                    NUM_PORT_BITS);
  localparam int LL     = leaf_lsb(PAYLOAD_BITS, NUM_PORT_BITS);
  localparam int PL     = port_lsb(PAYLOAD_BITS);
  localparam int DEST_W = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int RR_W   = (NUM_OUT_PORTS > 1) ?
                          $clog2(NUM_OUT_PORTS) : 1;

  logic [PKT_W-1:0]         r_in;
  logic                     w_in_vld;
  logic [NUM_PORT_BITS-1:0] w_in_port;
  logic [PAYLOAD_BITS-1:0]  w_in_data;
  logic                     w_unused_leaf;
  logic [NUM_IN_PORTS-1:0]  w_push;
  logic [NUM_IN_PORTS-1:0]  w_pop;
  logic [NUM_IN_PORTS-1:0]  w_full;
  logic [NUM_IN_PORTS-1:0]  w_empty;
  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] w_user_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_in <= '0;
    else          r_in <= bus.din_leaf_bft2interface;
  end

  assign w_in_vld      = r_in[VB];
  assign w_in_port     = r_in[PL +: NUM_PORT_BITS];
  assign w_in_data     = r_in[0 +: PAYLOAD_BITS];
  assign w_unused_leaf = ^r_in[LL +: NUM_LEAF_BITS];

  for (genvar p = 0; p < NUM_IN_PORTS; p++) begin : g_in
    assign w_push[p] = w_in_vld &&
                       (w_in_port == NUM_PORT_BITS'(p));
    assign w_pop[p]  = !w_empty[p] && bus.ack_user2interface[p];

    leaf_port_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PAYLOAD_BITS)
    ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_push  (w_push[p]),
      .i_data  (w_in_data),
      .i_pop   (w_pop[p]),
      .o_data  (w_user_data[p*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .o_full  (w_full[p]),
      .o_empty (w_empty[p])
    );
  end

  assign bus.dout_leaf_interface2user = w_user_data;
  assign bus.vld_interface2user       = ~w_empty;

  logic [RR_W-1:0]          r_rr;
  logic [RR_W-1:0]          w_gnt;
  logic [RR_W-1:0]          w_idx;
  logic                     w_gnt_vld;
  logic [NUM_OUT_PORTS-1:0] w_ack;
  logic [PKT_W-1:0]         r_out;

  // first requester at or after the pointer, wrapping
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      w_idx = RR_W'((int'(r_rr) + k) % NUM_OUT_PORTS);
      if (!w_gnt_vld && bus.vld_user2interface[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
  end

  always_comb begin
    w_ack = '0;
    if (w_gnt_vld && reset_n) w_ack[w_gnt] = 1'b1;
  end

  assign bus.ack_interface2user = w_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr  <= '0;
      r_out <= '0;
    end else if (w_gnt_vld) begin
      r_out <= {1'b1,
                bus.dest_cfg[int'(w_gnt)*DEST_W +: DEST_W],
                bus.din_leaf_user2interface[
                  int'(w_gnt)*PAYLOAD_BITS +: PAYLOAD_BITS]};
      r_rr  <= RR_W'((int'(w_gnt) + 1) % NUM_OUT_PORTS);
    end else begin
      r_out[VB] <= 1'b0;
    end
  end

  assign bus.dout_leaf_interface2bft = r_out;

`ifdef LEAF_BRIDGE_STATS_EN
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic                w_drop;
  logic                w_bad;
  logic [CNT_BITS-1:0] r_drop;
  logic [CNT_BITS-1:0] r_bad;
  logic [NUM_OUT_PORTS*TX_CNT_BITS-1:0] w_tx;

  assign w_drop = |(w_push & w_full & ~w_pop);
  assign w_bad  = w_in_vld && ({1'b0, w_in_port} >=
                  (NUM_PORT_BITS+1)'(NUM_IN_PORTS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop <= '0;
      r_bad  <= '0;
    end else begin
      if (w_drop && r_drop != CNT_MAX) r_drop <= r_drop + 1'b1;
      if (w_bad && r_bad != CNT_MAX)   r_bad  <= r_bad + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_tx
    logic [TX_CNT_BITS-1:0] r_tx;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_tx <= '0;
      else if (w_gnt_vld && w_gnt == RR_W'(i)) r_tx <= r_tx + 1'b1;
    end
    assign w_tx[i*TX_CNT_BITS +: TX_CNT_BITS] = r_tx;
  end

  assign bus.drop_cnt     = r_drop;
  assign bus.bad_port_cnt = r_bad;
  assign bus.tx_cnt       = w_tx;
`else
  logic w_unused_full;
  assign w_unused_full    = ^w_full;
  assign bus.drop_cnt     = '0;
  assign bus.bad_port_cnt = '0;
  assign bus.tx_cnt       = '0;
`endif

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// tb_leaf_stream_bridge: random traffic against a queue-based model of
// the bridge; a negedge monitor pops expected items as outputs appear.
module tb_leaf_stream_bridge;

  localparam int PB    = 32;
  localparam int LB    = 3;
  localparam int PTB   = 4;
  localparam int NIN   = 2;
  localparam int NOUT  = 2;
  localparam int DEPTH = 16;
  localparam int PKW   = 1 + LB + PTB + PB;
  localparam int DW    = LB + PTB;
`ifdef LEAF_BRIDGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  leaf_stream_bridge_if #(
    .PAYLOAD_BITS (PB), .NUM_LEAF_BITS (LB), .NUM_PORT_BITS (PTB),
    .NUM_IN_PORTS (NIN), .NUM_OUT_PORTS (NOUT)
  ) bus ();

  leaf_stream_bridge #(
    .PAYLOAD_BITS (PB), .NUM_LEAF_BITS (LB), .NUM_PORT_BITS (PTB),
    .NUM_IN_PORTS (NIN), .NUM_OUT_PORTS (NOUT), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  int          occ [NIN];
  bit          pend_v;
  int          pend_port;
  logic [31:0] pend_data;
  int          rr_m;
  int          cur_g;
  int          m_drop;
  int          m_bad;
  logic [31:0] m_tx [NOUT];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [PKW-1:0] exp_out [$];
  logic [NOUT-1:0] exp_ack;
  logic [PKW-1:0] last_out;
  logic [NOUT*DW-1:0] next_dest;
  bit mon_en = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_empty(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: DUT output with no expected item", name);
  endtask

  function automatic logic [PKW-1:0] mk(int port, logic [31:0] d);
    logic [LB-1:0] lf;
    lf = LB'($urandom_range(0, 7));
    return {1'b1, lf, PTB'(port), d};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NIN; p++) occ[p] = 0;
    for (int i = 0; i < NOUT; i++) m_tx[i] = '0;
    pend_v = 1'b0; pend_port = 0; pend_data = '0;
    rr_m = 0; cur_g = -1; m_drop = 0; m_bad = 0;
    q0.delete(); q1.delete(); exp_out.delete();
    exp_ack = '0; last_out = '0;
  endtask

  // effect of one rising edge on the model state
  task automatic edge_model();
    if (cur_g >= 0) begin
      m_tx[cur_g] = m_tx[cur_g] + 1;
      rr_m = (cur_g + 1) % NOUT;
    end
    for (int p = 0; p < NIN; p++)
      if (occ[p] > 0 && bus.ack_user2interface[p]) occ[p]--;
    if (pend_v) begin
      if (pend_port < NIN) begin
        if (occ[pend_port] < DEPTH) begin
          occ[pend_port]++;
          if (pend_port == 0) q0.push_back(pend_data);
          else q1.push_back(pend_data);
        end else if (m_drop < 65535) m_drop++;
      end else if (m_bad < 65535) m_bad++;
    end
    pend_v    = bus.din_leaf_bft2interface[PKW-1];
    pend_port = int'(bus.din_leaf_bft2interface[PB +: PTB]);
    pend_data = bus.din_leaf_bft2interface[PB-1:0];
  endtask

  task automatic comp_grant();
    cur_g = -1;
    for (int k = 0; k < NOUT; k++) begin
      int i;
      i = (rr_m + k) % NOUT;
      if (cur_g < 0 && bus.vld_user2interface[i]) cur_g = i;
    end
    exp_ack = '0;
    if (cur_g >= 0) begin
      exp_ack[cur_g] = 1'b1;
      exp_out.push_back({1'b1, bus.dest_cfg[cur_g*DW +: DW],
                         bus.din_leaf_user2interface[cur_g*PB +: PB]});
    end
  endtask

  task automatic cycle(logic [PKW-1:0] pkt, logic [NIN-1:0] ack,
                       logic [NOUT-1:0] vld);
    @(posedge clk);
    #1;
    edge_model();
    bus.din_leaf_bft2interface  = pkt;
    bus.ack_user2interface      = ack;
    bus.vld_user2interface      = vld;
    bus.din_leaf_user2interface = {$urandom, $urandom};
    bus.dest_cfg                = next_dest;
    comp_grant();
  endtask

  task automatic chk_counters(string tag);
    chk({tag, "_drop"}, bus.drop_cnt, STATS ? m_drop : 0);
    chk({tag, "_bad"}, bus.bad_port_cnt, STATS ? m_bad : 0);
    for (int i = 0; i < NOUT; i++)
      chk($sformatf("%s_tx%0d", tag, i), bus.tx_cnt[i*32 +: 32],
          STATS ? m_tx[i] : 32'd0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_dout"}, bus.dout_leaf_interface2bft, 0);
    chk({tag, "_vld"}, bus.vld_interface2user, 0);
    chk({tag, "_udata"}, bus.dout_leaf_interface2user, 0);
    chk({tag, "_ack"}, bus.ack_interface2user, 0);
    chk({tag, "_drop"}, bus.drop_cnt, 0);
    chk({tag, "_bad"}, bus.bad_port_cnt, 0);
    chk({tag, "_tx"}, bus.tx_cnt, 0);
  endtask

  // monitor: compares every visible output against the scoreboard
  initial begin
    logic [PKW-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("ack_out", bus.ack_interface2user, exp_ack);
        for (int p = 0; p < NIN; p++)
          chk($sformatf("vld_in%0d", p), bus.vld_interface2user[p],
              occ[p] > 0);
        if (bus.vld_interface2user[0] && bus.ack_user2interface[0]) begin
          if (q0.size() == 0) fail_empty("in0_data");
          else chk("in0_data", bus.dout_leaf_interface2user[31:0],
                   q0.pop_front());
        end
        if (bus.vld_interface2user[1] && bus.ack_user2interface[1]) begin
          if (q1.size() == 0) fail_empty("in1_data");
          else chk("in1_data", bus.dout_leaf_interface2user[63:32],
                   q1.pop_front());
        end
        if (bus.dout_leaf_interface2bft[PKW-1]) begin
          if (exp_out.size() == 0) fail_empty("egress_pkt");
          else begin
            e = exp_out.pop_front();
            chk("egress_pkt", bus.dout_leaf_interface2bft, e);
          end
          last_out = bus.dout_leaf_interface2bft;
        end else begin
          chk("egress_hold", bus.dout_leaf_interface2bft[PKW-2:0],
              last_out[PKW-2:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.din_leaf_bft2interface  = '0;
    bus.ack_user2interface      = '0;
    bus.din_leaf_user2interface = '0;
    bus.vld_user2interface      = 2'b11;
    next_dest = {7'((6 << 4) | 1), 7'((3 << 4) | 2)};
    bus.dest_cfg = next_dest;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    bus.vld_user2interface = '0;
    reset_n = 1'b1;
    comp_grant();
    mon_en = 1'b1;

    // single packet to port 1
    cycle(mk(1, 32'hDEADBEEF), 2'b00, 2'b00);
    cycle('0, 2'b00, 2'b00);
    cycle('0, 2'b00, 2'b00);
    chk("t1_vld", bus.vld_interface2user, 2'b10);
    chk("t1_data", bus.dout_leaf_interface2user[63:32], 32'hDEADBEEF);
    cycle('0, 2'b10, 2'b00);
    cycle('0, 2'b00, 2'b00);

    // overfill port 0, then push into full FIFO with a same-edge pop
    for (int i = 0; i < 17; i++) cycle(mk(0, $urandom), 2'b00, 2'b00);
    cycle('0, 2'b00, 2'b00);
    cycle('0, 2'b00, 2'b00);
    chk_counters("fill");
    cycle(mk(0, 32'hA5A5_0001), 2'b00, 2'b00);
    cycle('0, 2'b01, 2'b00);
    cycle('0, 2'b00, 2'b00);
    cycle('0, 2'b00, 2'b00);
    chk_counters("full_popush");
    cycle(mk(0, 32'hA5A5_0002), 2'b00, 2'b00);
    cycle('0, 2'b00, 2'b00);
    cycle('0, 2'b00, 2'b00);
    chk_counters("full_drop");
    repeat (20) cycle('0, 2'b01, 2'b00);
    chk("drain_vld", bus.vld_interface2user, 2'b00);

    // out-of-range port
    cycle(mk(5, 32'h0BAD_0005), 2'b00, 2'b00);
    cycle('0, 2'b00, 2'b00);
    cycle('0, 2'b00, 2'b00);
    chk("bad_vld", bus.vld_interface2user, 2'b00);
    chk_counters("bad");

    // both egress ports requesting every cycle
    repeat (8) cycle('0, 2'b00, 2'b11);
    cycle('0, 2'b00, 2'b00);
    cycle('0, 2'b00, 2'b00);
    chk_counters("egress");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 49) next_dest = 14'($urandom);
      cycle(($urandom_range(0, 9) < 7) ?
              mk($urandom_range(0, 3), $urandom) : '0,
            2'($urandom), 2'($urandom));
    end

    // reset in the middle of traffic
    cycle(mk(0, $urandom), 2'b11, 2'b11);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    model_reset();
    bus.din_leaf_bft2interface = '0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    comp_grant();
    #1;
    chk("post_rst_gnt", bus.ack_interface2user, 2'b01);

    for (int n = 0; n < 200; n++)
      cycle(($urandom_range(0, 9) < 8) ?
              mk($urandom_range(0, 2), $urandom) : '0,
            2'($urandom), 2'($urandom));

    repeat (40) cycle('0, 2'b11, 2'b00);
    chk("end_q0", q0.size(), 0);
    chk("end_q1", q1.size(), 0);
    chk("end_egress", exp_out.size(), 0);
    chk_counters("end");

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
